// File: rtl/dot_frame_buffer_if.sv
// Host/scanner bus for the dot-matrix frame buffer: back-buffer writes, commit,
// scroll control and the scanned-row readout.
interface dot_frame_buffer_if;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       commit;
  logic       scroll_en;
  logic       scroll_dir;
  logic [2:0] scan_row;
  logic [7:0] row_data;
  logic       pending;

  modport master (
    output wr_en, wr_row, wr_data, commit, scroll_en, scroll_dir, scan_row,
    input  wr_ready, row_data, pending
  );

  modport slave (
    input  wr_en, wr_row, wr_data, commit, scroll_en, scroll_dir, scan_row,
    output wr_ready, row_data, pending
  );
endinterface

// File: rtl/dot_frame_buffer.sv
// Double-buffered 8x8 bitmap feeding the row scanner; back->front swap only at
// frame boundaries, with optional periodic horizontal rotation of the front buffer.
module dot_frame_buffer #(
  parameter int SCROLL_FRAMES = 16
) (
  input  logic               div_clk,
  input  logic               reset,
  dot_frame_buffer_if.slave  bus
);

  localparam int CW = $clog2(SCROLL_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(SCROLL_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PEND, SWAP} state_e;

  state_e          state_q, state_d;
  logic [7:0][7:0] front_q, front_d;
  logic [7:0][7:0] back_q, back_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      prev_q;
  logic [7:0]      row_q;
  logic            ready_w, pend_w;
  logic            frame_end;

  assign frame_end    = (prev_q == 3'd7) && (bus.scan_row == 3'd0);
  assign bus.wr_ready = ready_w;
  assign bus.pending  = pend_w;
  assign bus.row_data = row_q;

  always_comb begin
    state_d = state_q;
    ready_w = 1'b0;
    pend_w  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_w = 1'b1;
        if (bus.commit) state_d = PEND;
      end
      PEND: begin
        pend_w = 1'b1;
        if (frame_end) state_d = SWAP;
      end
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write in the commit cycle is still accepted since wr_ready is IDLE-only.
  always_comb begin
    back_d = back_q;
    if (bus.wr_en && ready_w) back_d[bus.wr_row] = bus.wr_data;
  end

  // Swap and scroll are exclusive: scrolling only advances while IDLE, so a
  // boundary that triggers the swap never rotates.
  always_comb begin
    front_d = front_q;
    cnt_d   = cnt_q;
    if (state_q == SWAP) begin
      front_d = back_q;
      cnt_d   = '0;
    end else if (state_q == IDLE && frame_end && bus.scroll_en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        for (int i = 0; i < 8; i++) begin
          front_d[i] = bus.scroll_dir ? {front_q[i][0], front_q[i][7:1]}
                                      : {front_q[i][6:0], front_q[i][7]};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge div_clk) begin
    if (reset) begin
      state_q <= IDLE;
      front_q <= '0;
      back_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      back_q  <= back_d;
      cnt_q   <= cnt_d;
      prev_q  <= bus.scan_row;
      row_q   <= front_q[bus.scan_row];
    end
  end

endmodule

// File: tb/tb_dot_frame_buffer.sv
// Directed bench for dot_frame_buffer (SCROLL_FRAMES=2): reset, commit/swap
// timing, write lockout, scrolling, swap-vs-scroll priority and reset mid-commit.
module tb_dot_frame_buffer;

  localparam logic [7:0] GLYPH [8] = '{8'h18, 8'h24, 8'h42, 8'hC3,
                                       8'h42, 8'h42, 8'h42, 8'h7E};

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] cap [8];

  dot_frame_buffer_if bus ();

  dot_frame_buffer #(.SCROLL_FRAMES(2)) dut (
    .div_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rol(input logic [7:0] r);
    return {r[6:0], r[7]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    bus.scan_row = 3'd3;
    step();
  endtask

  // Reads all 8 front rows without creating a frame boundary.
  task automatic read_front();
    park();
    for (int r = 0; r < 8; r++) begin
      bus.scan_row = 3'(r);
      step();
      cap[r] = bus.row_data;
    end
    park();
  endtask

  // One full raw scan 0..7; a boundary occurs at its start if the row before was 7.
  task automatic scan_frame();
    for (int r = 0; r < 8; r++) begin
      bus.scan_row = 3'(r);
      step();
      cap[r] = bus.row_data;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.scan_row = 3'd7;
      step();
      bus.scan_row = 3'd0;
      step();
    end
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d, input logic cm);
    bus.wr_en   = 1'b1;
    bus.wr_row  = r;
    bus.wr_data = d;
    bus.commit  = cm;
    step();
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_tests++;
    if (bus.row_data !== 8'h00) begin n_fail++; $display("FAIL reset_row_data got %h want 00", bus.row_data); end
    n_tests++;
    if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
    n_tests++;
    if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", bus.pending); end
    read_front();
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (cap[r] !== 8'h00) begin n_fail++; $display("FAIL reset_front row %0d got %h want 00", r, cap[r]); end
    end
  endtask

  task automatic test_commit_swap();
    park();
    for (int r = 0; r < 8; r++) write_row(3'(r), GLYPH[r], 1'b0);
    do_commit();
    n_tests++;
    if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending got %b want 1", bus.pending); end
    n_tests++;
    if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL commit_wr_ready got %b want 0", bus.wr_ready); end
    scan_frame();
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (cap[r] !== 8'h00) begin n_fail++; $display("FAIL frame1_old row %0d got %h want 00", r, cap[r]); end
    end
    n_tests++;
    if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL frame1_pending got %b want 1", bus.pending); end
    scan_frame();
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (cap[r] !== ((r < 2) ? 8'h00 : GLYPH[r])) begin
        n_fail++; $display("FAIL frame2_swap row %0d got %h want %h", r, cap[r], (r < 2) ? 8'h00 : GLYPH[r]);
      end
    end
    n_tests++;
    if (cap[7] !== 8'h7E) begin n_fail++; $display("FAIL frame2_row7 got %h want 7e", cap[7]); end
    n_tests++;
    if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL swap_pending got %b want 0", bus.pending); end
    n_tests++;
    if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL swap_wr_ready got %b want 1", bus.wr_ready); end
    read_front();
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (cap[r] !== GLYPH[r]) begin n_fail++; $display("FAIL front_glyph row %0d got %h want %h", r, cap[r], GLYPH[r]); end
    end
  endtask

  task automatic test_write_in_pend();
    park();
    do_commit();
    write_row(3'd0, 8'hFF, 1'b0);
    n_tests++;
    if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL pend_wr_ready got %b want 0", bus.wr_ready); end
    frames(1);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h18) begin n_fail++; $display("FAIL pend_write_ignored got %h want 18", cap[0]); end
    n_tests++;
    if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL pend_done got %b want 0", bus.pending); end
  endtask

  task automatic test_scroll();
    bus.scroll_en  = 1'b1;
    bus.scroll_dir = 1'b0;
    frames(1);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h18) begin n_fail++; $display("FAIL scroll_one_frame got %h want 18", cap[0]); end
    frames(1);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h30) begin n_fail++; $display("FAIL scroll_left_row0 got %h want 30", cap[0]); end
    n_tests++;
    if (cap[7] !== 8'hFC) begin n_fail++; $display("FAIL scroll_left_row7 got %h want fc", cap[7]); end
    n_tests++;
    if (cap[3] !== 8'h87) begin n_fail++; $display("FAIL scroll_left_row3 got %h want 87", cap[3]); end
    frames(14);
    read_front();
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (cap[r] !== GLYPH[r]) begin n_fail++; $display("FAIL scroll_wrap row %0d got %h want %h", r, cap[r], GLYPH[r]); end
    end
    bus.scroll_dir = 1'b1;
    frames(2);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h0C) begin n_fail++; $display("FAIL scroll_right got %h want 0c", cap[0]); end
    frames(1);
    bus.scroll_en = 1'b0;
    frames(3);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h0C) begin n_fail++; $display("FAIL scroll_hold got %h want 0c", cap[0]); end
    bus.scroll_en = 1'b1;
    frames(1);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h06) begin n_fail++; $display("FAIL scroll_resume got %h want 06", cap[0]); end
  endtask

  task automatic test_swap_vs_scroll();
    bus.scroll_en  = 1'b1;
    bus.scroll_dir = 1'b1;
    frames(1);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h06) begin n_fail++; $display("FAIL pre_swap_row0 got %h want 06", cap[0]); end
    do_commit();
    frames(1);
    read_front();
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (cap[r] !== GLYPH[r]) begin n_fail++; $display("FAIL swap_unrotated row %0d got %h want %h", r, cap[r], GLYPH[r]); end
    end
    frames(1);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h18) begin n_fail++; $display("FAIL swap_cnt_cleared got %h want 18", cap[0]); end
    frames(1);
    read_front();
    n_tests++;
    if (cap[0] !== 8'h0C) begin n_fail++; $display("FAIL post_swap_scroll got %h want 0c", cap[0]); end
    bus.scroll_en = 1'b0;
  endtask

  task automatic test_reset_mid_pend();
    park();
    write_row(3'd2, 8'hAA, 1'b0);
    do_commit();
    bus.scan_row = 3'd6;
    step();
    bus.scan_row = 3'd0;
    step();
    n_tests++;
    if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL jump_not_frame_end got %b want 1", bus.pending); end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_tests++;
    if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL rst_pend_pending got %b want 0", bus.pending); end
    n_tests++;
    if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pend_wr_ready got %b want 1", bus.wr_ready); end
    read_front();
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (cap[r] !== 8'h00) begin n_fail++; $display("FAIL rst_pend_front row %0d got %h want 00", r, cap[r]); end
    end
    write_row(3'd3, 8'hC3, 1'b1);
    n_tests++;
    if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL recommit_pending got %b want 1", bus.pending); end
    frames(1);
    read_front();
    for (int r = 0; r < 8; r++) begin
      n_tests++;
      if (cap[r] !== ((r == 3) ? 8'hC3 : 8'h00)) begin
        n_fail++; $display("FAIL recommit_front row %0d got %h want %h", r, cap[r], (r == 3) ? 8'hC3 : 8'h00);
      end
    end
    n_tests++;
    if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL recommit_done got %b want 0", bus.pending); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_row     = 3'd0;
    bus.wr_data    = 8'h00;
    bus.commit     = 1'b0;
    bus.scroll_en  = 1'b0;
    bus.scroll_dir = 1'b0;
    bus.scan_row   = 3'd3;
    test_reset();
    test_commit_swap();
    test_write_in_pend();
    test_scroll();
    test_swap_vs_scroll();
    test_reset_mid_pend();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Unused-result sanity: rol is exercised here so the left-rotate constants above stay consistent.
  initial begin
    #1;
    n_tests++;
    if (rol(GLYPH[0]) !== 8'h30) begin n_fail++; $display("FAIL rol_model got %h want 30", rol(GLYPH[0])); end
  end

endmodule
